matrix_store_sequencer: RTL

MATRIX_STORE_SEQUENCER -- requirements
Module: matrix_store_sequencer

---
 rtl/matrix_store_sequencer_pkg.sv | 36 +++
 rtl/matrix_store_sequencer_arb.sv | 41 ++++
 rtl/matrix_store_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_store_sequencer_pkg.sv
// Shared constants, state encoding and payload types for the matrix store sequencer.
package matrix_store_sequencer_pkg;

   localparam int unsigned ELEMENT_WIDTH  = 16;
   localparam int unsigned MAX_MATRIX_DIM = 16;

   localparam int unsigned DIM_W  = 5;
   localparam int unsigned SLOT_W = 4;
   localparam int unsigned IDX_W  = 10;
   localparam int unsigned ERR_W  = 2;

   localparam logic [ERR_W-1:0] ERR_NONE     = 2'd0;
   localparam logic [ERR_W-1:0] ERR_BAD_DIM  = 2'd1;
   localparam logic [ERR_W-1:0] ERR_NO_SPACE = 2'd2;
   localparam logic [ERR_W-1:0] ERR_ABORTED  = 2'd3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALLOC  = 3'd1,
      AWAIT  = 3'd2,
      WRITE  = 3'd3,
      COMMIT = 3'd4
   } state_e;

   typedef struct packed {
      logic [DIM_W-1:0] m;
      logic [DIM_W-1:0] n;
   } dims_t;

   // A matrix shape is storable when both sides are non-zero and within max_dim.
   function automatic logic dims_legal(input dims_t d, input int unsigned max_dim);
      return (d.m != '0) && (d.n != '0) &&
             (32'(d.m) <= max_dim) && (32'(d.n) <= max_dim);
   endfunction

endpackage

// File: rtl/matrix_store_sequencer_arb.sv
// Two-port round-robin arbiter; the last-granted pointer resets to port 1 so port 0 wins first.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,
   input  logic       ack_i,
   output logic [1:0] gnt_c_o,
   output logic       idx_c_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      idx_c_o = 1'b0;
      case (req_i)
         2'b01:   idx_c_o = 1'b0;
         2'b10:   idx_c_o = 1'b1;
         2'b11:   idx_c_o = ~last_q;
         default: idx_c_o = 1'b0;
      endcase
      gnt_c_o = '0;
      if (en_i && (req_i != '0)) begin
         gnt_c_o[idx_c_o] = 1'b1;
      end
      last_d = last_q;
      if (ack_i) begin
         last_d = idx_c_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/matrix_store_sequencer.sv
// Arbitrates two store requesters, allocates a slot, streams elements into BRAM and commits.
module matrix_store_sequencer #(
   parameter int unsigned ELEMENT_WIDTH = matrix_store_sequencer_pkg::ELEMENT_WIDTH,
   parameter int unsigned MAX_DIM       = matrix_store_sequencer_pkg::MAX_MATRIX_DIM,
   parameter int unsigned ADDR_WIDTH    = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [9:0]                 req_m,
   input  logic [9:0]                 req_n,
   input  logic [1:0]                 in_valid,
   output logic [1:0]                 in_ready,
   input  logic [2*ELEMENT_WIDTH-1:0] in_data,
   input  logic                       abort,
   output logic                       alloc_req,
   input  logic                       alloc_valid,
   input  logic [3:0]                 alloc_slot,
   input  logic [ADDR_WIDTH-1:0]      alloc_addr,
   output logic [4:0]                 mat_m,
   output logic [4:0]                 mat_n,
   output logic                       commit_req,
   output logic [3:0]                 commit_slot,
   output logic [ADDR_WIDTH-1:0]      commit_addr,
   output logic                       bram_we,
   output logic [ADDR_WIDTH-1:0]      bram_waddr,
   output logic [ELEMENT_WIDTH-1:0]   bram_wdata,
   output logic                       done,
   output logic [3:0]                 done_slot,
   output logic                       err,
   output logic [1:0]                 err_code
);

   import matrix_store_sequencer_pkg::*;

   state_e                  state_q, state_d;
   dims_t                   dims_q, dims_d;
   logic                    gidx_q, gidx_d;
   logic [IDX_W-1:0]        total_q, total_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic [ELEMENT_WIDTH-1:0] wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic                    alloc_req_q, alloc_req_d;
   logic                    commit_q, commit_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [ERR_W-1:0]        err_code_q, err_code_d;
   logic [1:0]              in_ready_q, in_ready_d;

   logic [1:0]              gnt_c;
   logic                    gnt_idx_c;
   logic                    accept_c;
   dims_t                   req_dims_c;
   logic                    dims_ok_c;
   logic                    hs_c;
   logic                    last_c;
   logic [ELEMENT_WIDTH-1:0] elem_c;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (state_q == IDLE),
      .req_i   (req_valid),
      .ack_i   (accept_c),
      .gnt_c_o (gnt_c),
      .idx_c_o (gnt_idx_c)
   );

   assign req_ready    = gnt_c;
   assign accept_c     = |(req_valid & gnt_c);
   assign req_dims_c.m = gnt_idx_c ? req_m[9:5] : req_m[4:0];
   assign req_dims_c.n = gnt_idx_c ? req_n[9:5] : req_n[4:0];
   assign dims_ok_c    = dims_legal(req_dims_c, MAX_DIM);
   assign elem_c       = gidx_q ? in_data[2*ELEMENT_WIDTH-1:ELEMENT_WIDTH]
                                : in_data[ELEMENT_WIDTH-1:0];
   assign hs_c         = (state_q == WRITE) && in_valid[gidx_q] && in_ready_q[gidx_q];
   assign last_c       = (idx_q == (total_q - IDX_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort wins over allocation results and over the final element handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c && dims_ok_c) begin
               state_d = ALLOC;
            end
         end
         ALLOC:  state_d = abort ? IDLE : AWAIT;
         AWAIT: begin
            if (abort || !alloc_valid) begin
               state_d = IDLE;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (hs_c && last_c) begin
               state_d = COMMIT;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dims_d      = dims_q;
      gidx_d      = gidx_q;
      total_d     = total_q;
      idx_d       = idx_q;
      slot_d      = slot_q;
      base_d      = base_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      done_d      = (state_q == COMMIT);
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      alloc_req_d = (state_d == ALLOC);
      commit_d    = (state_d == COMMIT);
      in_ready_d  = '0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               dims_d  = req_dims_c;
               gidx_d  = gnt_idx_c;
               total_d = IDX_W'(req_dims_c.m) * IDX_W'(req_dims_c.n);
               idx_d   = '0;
               if (!dims_ok_c) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BAD_DIM;
               end
            end
         end
         ALLOC: begin
            if (abort) begin
               err_d      = 1'b1;
               err_code_d = ERR_ABORTED;
            end
         end
         AWAIT: begin
            if (abort) begin
               err_d      = 1'b1;
               err_code_d = ERR_ABORTED;
            end else if (alloc_valid) begin
               slot_d = alloc_slot;
               base_d = alloc_addr;
            end else begin
               err_d      = 1'b1;
               err_code_d = ERR_NO_SPACE;
            end
         end
         WRITE: begin
            if (abort) begin
               err_d      = 1'b1;
               err_code_d = ERR_ABORTED;
            end else if (hs_c) begin
               we_d    = 1'b1;
               waddr_d = base_q + ADDR_WIDTH'(idx_q);
               wdata_d = elem_c;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase

      if (state_d == WRITE) begin
         in_ready_d[gidx_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dims_q      <= '0;
         gidx_q      <= 1'b0;
         total_q     <= '0;
         idx_q       <= '0;
         slot_q      <= '0;
         base_q      <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         alloc_req_q <= 1'b0;
         commit_q    <= 1'b0;
         in_ready_q  <= '0;
      end else begin
         dims_q      <= dims_d;
         gidx_q      <= gidx_d;
         total_q     <= total_d;
         idx_q       <= idx_d;
         slot_q      <= slot_d;
         base_q      <= base_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         alloc_req_q <= alloc_req_d;
         commit_q    <= commit_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign alloc_req   = alloc_req_q;
   assign mat_m       = dims_q.m;
   assign mat_n       = dims_q.n;
   assign commit_req  = commit_q;
   assign commit_slot = slot_q;
   assign commit_addr = base_q;
   assign bram_we     = we_q;
   assign bram_waddr  = waddr_q;
   assign bram_wdata  = wdata_q;
   assign done        = done_q;
   assign done_slot   = slot_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule
